spi_note_decoder: RTL

SPI slave front end that receives note commands from the host MCU and turns them into the register-plus-strobe command interface consumed by `voice_controller`. It synchronises the SPI pins into the system clock domain and assembles bytes into framed packets. It validates each packet and, on a complete valid frame, updates the held command registers and pulses `o_flag_dds` and/or `o_flag_adsr` for one clock.

---
 rtl/spi_note_decoder.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_note_decoder.sv
// SPI mode-0 slave that turns NOTE_ON / NOTE_OFF packets into held command
// registers plus one-cycle strobes for the voice controller.
module spi_note_decoder #(
    parameter int NUM_VOICES  = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sck,
    input  logic        i_mosi,
    input  logic        i_cs_n,
    output logic        o_note_status,
    output logic [7:0]  o_voice_index,
    output logic [7:0]  o_velocity,
    output logic [31:0] o_tuning_code,
    output logic        o_flag_dds,
    output logic        o_flag_adsr,
    output logic        o_frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PAYLOAD,
        COMMIT,
        WAIT_CS,
        DISCARD
    } state_t;

    localparam logic [7:0] CMD_NOTE_ON  = 8'h01;
    localparam logic [7:0] CMD_NOTE_OFF = 8'h02;
    localparam int         LIMIT_INT    = (NUM_VOICES > 256) ? 256 : NUM_VOICES;
    localparam logic [8:0] VOICE_LIMIT  = 9'(LIMIT_INT);

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES:0]   arm_pipe;

    logic sck_s, mosi_s, cs_s;
    logic sck_q, cs_q, mosi_q;
    logic sck_rise, cs_rise, cs_fall;

    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;
    logic [6:0] shift;
    logic [7:0] byte_val;
    logic       in_frame;
    logic       byte_done;
    logic       last_byte;
    logic       cmd_known;
    logic       voice_ok;

    logic        note_on_sh;
    logic [2:0]  frame_len;
    logic [7:0]  voice_sh;
    logic [7:0]  vel_sh;
    logic [31:0] tune_sh;

    logic start_frame;
    logic load_cmd;
    logic commit_on;
    logic commit_off;
    logic err_d;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    assign in_frame  = (state == CMD) || (state == PAYLOAD);
    assign byte_val  = {shift, mosi_q};
    assign byte_done = in_frame && sck_rise && (bit_cnt == 3'd7);
    assign last_byte = (byte_cnt == (frame_len - 3'd1));
    assign cmd_known = (byte_val == CMD_NOTE_ON) || (byte_val == CMD_NOTE_OFF);
    assign voice_ok  = ({1'b0, voice_sh} < VOICE_LIMIT);

    // Synchronise the asynchronous SPI pins; arm_pipe marks when the
    // CS chain holds real pin data so a low CS after reset is not a fall.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            arm_pipe  <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            arm_pipe  <= {arm_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Registered edge detection keeps SCK, MOSI and CS events aligned.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sck_q    <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            sck_rise <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
        end else begin
            sck_q    <= sck_s;
            cs_q     <= cs_s;
            mosi_q   <= mosi_s;
            sck_rise <= sck_s & ~sck_q;
            cs_rise  <= cs_s & ~cs_q;
            cs_fall  <= ~cs_s & cs_q & arm_pipe[SYNC_STAGES];
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state and per-cycle control decisions.
    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        load_cmd    = 1'b0;
        commit_on   = 1'b0;
        commit_off  = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = CMD;
                    start_frame = 1'b1;
                end
            end
            CMD: begin
                if (byte_done) begin
                    if (!cmd_known) begin
                        state_d = DISCARD;
                    end else if (cs_rise) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        load_cmd = 1'b1;
                        state_d  = PAYLOAD;
                    end
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            PAYLOAD: begin
                if (byte_done && last_byte) begin
                    state_d = COMMIT;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                if (!voice_ok) begin
                    err_d = 1'b1;
                end else if (note_on_sh) begin
                    commit_on = 1'b1;
                end else begin
                    commit_off = 1'b1;
                end
                state_d = cs_q ? IDLE : WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_fall) begin
                    state_d     = CMD;
                    start_frame = 1'b1;
                end else if (cs_q) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (cs_fall) begin
                    err_d       = 1'b1;
                    state_d     = CMD;
                    start_frame = 1'b1;
                end else if (cs_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit/byte counters and the MOSI shift register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else if (start_frame) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shift    <= '0;
        end else if (in_frame && sck_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= byte_val[6:0];
            if (bit_cnt == 3'd7) begin
                byte_cnt <= byte_cnt + 3'd1;
            end
        end
    end

    // Shadow registers collect the packet until it is committed.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            note_on_sh <= 1'b0;
            frame_len  <= '0;
            voice_sh   <= '0;
            vel_sh     <= '0;
            tune_sh    <= '0;
        end else if (start_frame) begin
            note_on_sh <= 1'b0;
            frame_len  <= '0;
            voice_sh   <= '0;
            vel_sh     <= '0;
            tune_sh    <= '0;
        end else if (load_cmd) begin
            note_on_sh <= (byte_val == CMD_NOTE_ON);
            frame_len  <= (byte_val == CMD_NOTE_ON) ? 3'd7 : 3'd2;
        end else if ((state == PAYLOAD) && byte_done) begin
            case (byte_cnt)
                3'd1:    voice_sh        <= byte_val;
                3'd2:    vel_sh          <= byte_val;
                3'd3:    tune_sh[31:24]  <= byte_val;
                3'd4:    tune_sh[23:16]  <= byte_val;
                3'd5:    tune_sh[15:8]   <= byte_val;
                3'd6:    tune_sh[7:0]    <= byte_val;
                default: voice_sh        <= voice_sh;
            endcase
        end
    end

    // Held command registers and one-cycle strobes, written only on commit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_note_status <= 1'b0;
            o_voice_index <= '0;
            o_velocity    <= '0;
            o_tuning_code <= '0;
            o_flag_dds    <= 1'b0;
            o_flag_adsr   <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_flag_dds    <= commit_on;
            o_flag_adsr   <= commit_on | commit_off;
            o_frame_error <= err_d;
            if (commit_on) begin
                o_note_status <= 1'b1;
                o_voice_index <= voice_sh;
                o_velocity    <= vel_sh;
                o_tuning_code <= tune_sh;
            end else if (commit_off) begin
                o_note_status <= 1'b0;
                o_voice_index <= voice_sh;
            end
        end
    end

endmodule
